// File: rtl/ccc_apb_cfg_master.sv
// ============================================================================
// Module   : ccc_apb_cfg_master
// Brief    : APB initiator that loads CCC configuration bytes from a table,
//            optionally reads them back, then qualifies PLL lock.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ccc_apb_cfg_master #(
    parameter int NUM_REGS = 27,
    parameter int VERIFY   = 1,
    parameter int TIMEOUT  = 4095
) (
    input  logic       PCLK,
    input  logic       PRESET_N,
    input  logic       START,
    output logic [5:0] CFG_IDX,
    input  logic [7:0] CFG_DATA,
    output logic       PSEL,
    output logic       PENABLE,
    output logic       PWRITE,
    output logic [5:0] PADDR,
    output logic [7:0] PWDATA,
    input  logic [7:0] PRDATA,
    input  logic       CCC_BUSY,
    input  logic       LOCK,
    output logic       ACTIVE,
    output logic       DONE,
    output logic [1:0] ERR
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_BUSY = 3'd1,
        S_SETUP     = 3'd2,
        S_ACCESS    = 3'd3,
        S_WAIT_LOCK = 3'd4,
        S_DONE      = 3'd5,
        S_FAIL      = 3'd6
    } state_t;

    localparam logic [5:0]  c_LAST_IDX     = 6'(NUM_REGS - 1);
    localparam logic [11:0] c_TMO_LAST     = 12'(TIMEOUT - 1);
    localparam logic [11:0] c_TMO_MAX      = 12'hFFF;
    localparam logic [4:0]  c_LOCK_LAST    = 5'd15;
    localparam logic [1:0]  c_ERR_NONE     = 2'b00;
    localparam logic [1:0]  c_ERR_MISMATCH = 2'b01;
    localparam logic [1:0]  c_ERR_LOCK     = 2'b10;
    localparam logic [1:0]  c_ERR_BUSY     = 2'b11;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [5:0]  r_idx;
    logic [5:0]  w_idx_nxt;
    logic        r_phase_rd;
    logic        w_phase_rd_nxt;
    logic [1:0]  w_err_nxt;
    logic [11:0] r_tcnt;
    logic [4:0]  r_lock_cnt;
    logic [4:0]  w_lock_cnt_nxt;
    logic        r_lock_meta;
    logic        r_lock_sync;
    logic        w_active_nxt;

    assign CFG_IDX = r_idx;

    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_phase_rd_nxt = r_phase_rd;
        w_err_nxt      = ERR;
        w_lock_cnt_nxt = 5'd0;
        case (r_state)
            S_IDLE, S_DONE, S_FAIL: begin
                if (START) begin
                    w_state_nxt    = S_WAIT_BUSY;
                    w_idx_nxt      = 6'd0;
                    w_phase_rd_nxt = 1'b0;
                    w_err_nxt      = c_ERR_NONE;
                end
            end
            S_WAIT_BUSY: begin
                if (!CCC_BUSY) begin
                    w_state_nxt = S_SETUP;
                end else if (r_tcnt == c_TMO_LAST) begin
                    w_state_nxt = S_FAIL;
                    w_err_nxt   = c_ERR_BUSY;
                end
            end
            S_SETUP: w_state_nxt = S_ACCESS;
            S_ACCESS: begin
                if (r_phase_rd && (PRDATA != CFG_DATA)) begin
                    w_state_nxt = S_FAIL;
                    w_err_nxt   = c_ERR_MISMATCH;
                end else if (r_idx != c_LAST_IDX) begin
                    w_idx_nxt   = r_idx + 6'd1;
                    w_state_nxt = S_WAIT_BUSY;
                end else if (!r_phase_rd && (VERIFY != 0)) begin
                    w_idx_nxt      = 6'd0;
                    w_phase_rd_nxt = 1'b1;
                    w_state_nxt    = S_WAIT_BUSY;
                end else begin
                    w_state_nxt = S_WAIT_LOCK;
                end
            end
            S_WAIT_LOCK: begin
                // Any low synchronized sample restarts the 16-cycle qualification.
                w_lock_cnt_nxt = r_lock_sync ? (r_lock_cnt + 5'd1) : 5'd0;
                if (r_lock_sync && (r_lock_cnt == c_LOCK_LAST)) begin
                    w_state_nxt = S_DONE;
                end else if (r_tcnt == c_TMO_LAST) begin
                    w_state_nxt = S_FAIL;
                    w_err_nxt   = c_ERR_LOCK;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_active_nxt = (w_state_nxt == S_WAIT_BUSY) || (w_state_nxt == S_SETUP) ||
                          (w_state_nxt == S_ACCESS)    || (w_state_nxt == S_WAIT_LOCK);

    always_ff @(posedge PCLK) begin
        if (!PRESET_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESET_N) begin
            r_idx       <= 6'd0;
            r_phase_rd  <= 1'b0;
            r_tcnt      <= 12'd0;
            r_lock_cnt  <= 5'd0;
            r_lock_meta <= 1'b0;
            r_lock_sync <= 1'b0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= 6'd0;
            PWDATA      <= 8'd0;
            ACTIVE      <= 1'b0;
            DONE        <= 1'b0;
            ERR         <= c_ERR_NONE;
        end else begin
            r_idx      <= w_idx_nxt;
            r_phase_rd <= w_phase_rd_nxt;
            if (w_state_nxt != r_state) begin
                r_tcnt <= 12'd0;
            end else if (((r_state == S_WAIT_BUSY) || (r_state == S_WAIT_LOCK)) &&
                         (r_tcnt != c_TMO_MAX)) begin
                r_tcnt <= r_tcnt + 12'd1;
            end
            r_lock_cnt <= (r_state == S_WAIT_LOCK) ? w_lock_cnt_nxt : 5'd0;
            // Flushed outside WAIT_LOCK so a stale lock never shortcuts qualification.
            r_lock_meta <= (r_state == S_WAIT_LOCK) ? LOCK : 1'b0;
            r_lock_sync <= (r_state == S_WAIT_LOCK) ? r_lock_meta : 1'b0;
            PSEL    <= (w_state_nxt == S_SETUP) || (w_state_nxt == S_ACCESS);
            PENABLE <= (w_state_nxt == S_ACCESS);
            if (w_state_nxt == S_SETUP) begin
                PADDR  <= r_idx;
                PWRITE <= !r_phase_rd;
                PWDATA <= r_phase_rd ? 8'd0 : CFG_DATA;
            end else if (w_state_nxt != S_ACCESS) begin
                PWRITE <= 1'b0;
                PWDATA <= 8'd0;
            end
            ACTIVE <= w_active_nxt;
            DONE   <= (w_state_nxt == S_DONE);
            ERR    <= w_err_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ccc_apb_cfg_master.sv
// ============================================================================
// Module   : tb_ccc_apb_cfg_master
// Brief    : Directed/randomized bench for ccc_apb_cfg_master with a
//            transfer-list reference model and APB responder memories.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ccc_apb_cfg_master;

    localparam int N   = 4;
    localparam int TMO = 100;

    typedef struct packed {
        logic       wr;
        logic [5:0] addr;
        logic [7:0] data;
    } xfer_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, busy, lock, corrupt;
    logic [7:0] tbl  [0:63];
    logic [7:0] mem0 [0:63];
    logic [7:0] mem1 [0:63];

    logic [5:0] idx0, idx1, paddr0, paddr1;
    logic [7:0] cd0, cd1, pwd0, pwd1, prd0, prd1;
    logic       psel0, pen0, pwr0, act0, done0;
    logic       psel1, pen1, pwr1, act1, done1;
    logic [1:0] err0, err1;

    int checks   = 0;
    int failures = 0;

    xfer_t log0[$];
    xfer_t log1[$];
    xfer_t exp_q[$];

    assign cd0  = tbl[idx0];
    assign cd1  = tbl[idx1];
    assign prd0 = mem0[paddr0];
    assign prd1 = (corrupt && paddr1 == 6'd2) ? 8'h01 : mem1[paddr1];

    ccc_apb_cfg_master #(.NUM_REGS(N), .VERIFY(0), .TIMEOUT(TMO)) dut0 (
        .PCLK(clk), .PRESET_N(rst_n), .START(start), .CFG_IDX(idx0), .CFG_DATA(cd0),
        .PSEL(psel0), .PENABLE(pen0), .PWRITE(pwr0), .PADDR(paddr0), .PWDATA(pwd0),
        .PRDATA(prd0), .CCC_BUSY(busy), .LOCK(lock), .ACTIVE(act0), .DONE(done0), .ERR(err0));

    ccc_apb_cfg_master #(.NUM_REGS(N), .VERIFY(1), .TIMEOUT(TMO)) dut1 (
        .PCLK(clk), .PRESET_N(rst_n), .START(start), .CFG_IDX(idx1), .CFG_DATA(cd1),
        .PSEL(psel1), .PENABLE(pen1), .PWRITE(pwr1), .PADDR(paddr1), .PWDATA(pwd1),
        .PRDATA(prd1), .CCC_BUSY(busy), .LOCK(lock), .ACTIVE(act1), .DONE(done1), .ERR(err1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Responder: the CCC register file as seen over APB.
    always @(posedge clk) begin
        if (psel0 && pen0 && pwr0) mem0[paddr0] <= pwd0;
        if (psel1 && pen1 && pwr1) mem1[paddr1] <= pwd1;
    end

    logic  prev_setup0 = 1'b0, prev_setup1 = 1'b0;
    xfer_t prev_x0 = '0, prev_x1 = '0;

    always @(negedge clk) begin
        if (pen0 === 1'b1) begin
            log0.push_back({pwr0, paddr0, pwd0});
            chk("access_after_setup0", {prev_setup0, prev_x0}, {1'b1, pwr0, paddr0, pwd0});
        end
        if (psel0 !== 1'b1) chk("idle_bus0", {pen0, pwr0, pwd0}, 32'd0);
        prev_setup0 = psel0 && !pen0;
        prev_x0     = {pwr0, paddr0, pwd0};
        if (pen1 === 1'b1) begin
            log1.push_back({pwr1, paddr1, pwd1});
            chk("access_after_setup1", {prev_setup1, prev_x1}, {1'b1, pwr1, paddr1, pwd1});
        end
        if (psel1 !== 1'b1) chk("idle_bus1", {pen1, pwr1, pwd1}, 32'd0);
        prev_setup1 = psel1 && !pen1;
        prev_x1     = {pwr1, paddr1, pwd1};
    end

    // Reference: every register written in order, then (verify) read in order
    // until the first mismatching address, after which nothing more is issued.
    task automatic build_exp(input bit verify, input int bad);
        exp_q.delete();
        for (int i = 0; i < N; i++) exp_q.push_back({1'b1, 6'(i), tbl[i]});
        if (verify) begin
            for (int i = 0; i < N; i++) begin
                exp_q.push_back({1'b0, 6'(i), 8'h00});
                if (i == bad) break;
            end
        end
    endtask

    task automatic cmp_log(input string tag, input bit which);
        xfer_t got[$];
        got = which ? log1 : log0;
        chk({tag, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk($sformatf("%s_xfer%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_end(input bit which, input int max, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (n < max && !(which ? (done1 || err1 != 2'b00) : (done0 || err0 != 2'b00)));
    endtask

    task automatic wait_access0(input logic [5:0] addr);
        bit found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            @(negedge clk);
            found = pen0 && (paddr0 == addr);
        end
        chk($sformatf("access_seen_addr%0d", addr), 32'(found), 32'd1);
    endtask

    task automatic rand_table();
        for (int i = 0; i < 64; i++) tbl[i] = 8'($urandom);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; start = 1'b0; busy = 1'b0; lock = 1'b1; corrupt = 1'b0;
        rand_table();
        tbl[0] = 8'hA5; tbl[1] = 8'h3C; tbl[2] = 8'h00; tbl[3] = 8'hFF;
        repeat (2) @(negedge clk);
        chk("reset_outputs0", {psel0, pen0, pwr0, paddr0, pwd0, act0, done0, err0}, 32'd0);
        chk("reset_outputs1", {psel1, pen1, pwr1, paddr1, pwd1, act1, done1, err1}, 32'd0);
        chk("reset_idx", {idx0, idx1}, 32'd0);
        rst_n = 1'b1;

        // Fixed table, no busy, lock steady: write-only and write+verify latency.
        log0.delete(); log1.delete();
        pulse_start();
        chk("active_after_start", {act0, act1}, 32'b11);
        wait_end(1'b0, 200, n);
        chk("done_latency0", n, 3 * N + 2 + 16);
        chk("done_err0", {done0, act0, err0}, {1'b1, 1'b0, 2'b00});
        build_exp(1'b0, -1);
        cmp_log("wr_only", 1'b0);
        begin
            int n1;
            wait_end(1'b1, 200, n1);
            chk("done_latency1", n + n1, 3 * 2 * N + 2 + 16);
        end
        chk("done_err1", {done1, act1, err1}, {1'b1, 1'b0, 2'b00});
        build_exp(1'b1, -1);
        cmp_log("wr_rd", 1'b1);

        // Readback mismatch at address 2.
        rand_table();
        if (tbl[2] == 8'h01) tbl[2] = 8'h5A;
        log0.delete(); log1.delete();
        corrupt = 1'b1;
        pulse_start();
        wait_end(1'b1, 200, n);
        repeat (10) @(negedge clk);
        chk("mismatch_err", {done1, act1, err1}, {1'b0, 1'b0, 2'b01});
        build_exp(1'b1, 2);
        cmp_log("mismatch", 1'b1);
        corrupt = 1'b0;

        // CCC_BUSY held high ahead of the second write.
        log0.delete(); log1.delete();
        pulse_start();
        wait_access0(6'd0);
        busy = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("busy_psel_low%0d", k), psel0, 1'b0);
        end
        busy = 1'b0;
        wait_end(1'b0, 200, n);
        chk("busy_done0", {done0, err0}, {1'b1, 2'b00});
        build_exp(1'b0, -1);
        cmp_log("busy_hold", 1'b0);
        wait_end(1'b1, 200, n);

        // Random busy pattern and random table, with an ignored mid-run START.
        rand_table();
        log0.delete(); log1.delete();
        pulse_start();
        for (int k = 0; k < 500 && !(done1 || err1 != 2'b00); k++) begin
            busy  = ($urandom_range(0, 2) == 0);
            start = (k == 5);
            @(negedge clk);
        end
        busy = 1'b0; start = 1'b0;
        chk("rand_done1", {done1, err1}, {1'b1, 2'b00});
        build_exp(1'b1, -1);
        cmp_log("rand_busy", 1'b1);
        wait_end(1'b0, 200, n);
        chk("rand_done0", {done0, err0}, {1'b1, 2'b00});

        // LOCK toggling every 8 cycles never qualifies; then steady high does.
        lock = 1'b0;
        pulse_start();
        repeat (3 * N) @(negedge clk);
        for (int p = 0; p < 8; p++) begin
            lock = ~lock;
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                chk($sformatf("toggle_no_done_p%0d", p), {done0, err0}, 32'd0);
            end
        end
        lock = 1'b1;
        wait_end(1'b0, 40, n);
        chk("lock_qual_latency", n, 2 + 16);
        chk("lock_done0", {done0, err0}, {1'b1, 2'b00});
        wait_end(1'b1, 200, n);

        // LOCK held low: lock timeout.
        lock = 1'b0;
        pulse_start();
        wait_end(1'b0, TMO + 60, n);
        chk("lock_tmo_latency", n, 3 * N + TMO);
        chk("lock_tmo_err", {done0, act0, err0}, {1'b0, 1'b0, 2'b10});
        wait_end(1'b1, TMO + 60, n);
        chk("lock_tmo_err1", err1, 2'b10);
        lock = 1'b1;

        // CCC_BUSY stuck high: busy timeout.
        busy = 1'b1;
        pulse_start();
        wait_end(1'b0, TMO + 20, n);
        chk("busy_tmo_latency", n, TMO);
        chk("busy_tmo_err", {done0, act0, err0}, {1'b0, 1'b0, 2'b11});
        busy = 1'b0;

        // Reset during ACCESS of the second write, with START asserted alongside.
        pulse_start();
        wait_access0(6'd1);
        rst_n = 1'b0; start = 1'b1;
        @(negedge clk);
        chk("midreset_out0", {psel0, pen0, pwr0, paddr0, pwd0, act0, done0, err0}, 32'd0);
        chk("midreset_out1", {psel1, pen1, pwr1, paddr1, pwd1, act1, done1, err1}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; start = 1'b0;
        @(negedge clk);
        chk("reset_beats_start", {act0, act1}, 32'd0);

        // Restart after DONE begins again at address 0 with DONE cleared.
        pulse_start();
        wait_end(1'b0, 200, n);
        chk("pre_restart_done", done0, 1'b1);
        log0.delete(); log1.delete();
        pulse_start();
        chk("restart_clears_done", {done0, act0}, {1'b0, 1'b1});
        wait_end(1'b0, 200, n);
        chk("restart_done", {done0, err0}, {1'b1, 2'b00});
        build_exp(1'b0, -1);
        cmp_log("restart", 1'b0);
        wait_end(1'b1, 200, n);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
